apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
Shares one APB master port between NREQ independent requesters, e.g. the AHB-to-APB bridge write path, a DMA engine and a debug port. Performs round-robin arbitration and drives the APB SETUP/ACCESS sequencing, including pready wait states. Returns a per-requester response pulse with read data and error status. Sits between the requester blocks and the APB slave decoder.

Parameters:
NREQ, 4, number of requesters (2..8)
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT_CYC, 16, wait-state limit; used only when APB_TIMEOUT_EN is defined

Ports:
hclk  input  1  clock
hresetn  input  1  asynchronous active-low reset
req_valid  input  NREQ  request pending, one bit per requester
req_write  input  NREQ  1 = write, 0 = read
req_addr  input  NREQ*ADDR_W  flattened; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NREQ*DATA_W  flattened write data
req_ready  output  NREQ  combinational one-hot accept strobe
rsp_valid  output  NREQ  registered one-hot completion pulse
rsp_rdata  output  DATA_W  read data, valid with rsp_valid
rsp_err  output  1  pslverr (or timeout) status, valid with rsp_valid
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_W  APB address
pwdata  output  DATA_W  APB write data
prdata  input  DATA_W  APB read data
pready  input  1  APB ready / wait-state insert
pslverr  input  1  APB slave error

Behaviour:
- Reset (async, hresetn=0): all outputs 0 (psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err), state IDLE, rr pointer 0. Requester 0 has top priority after reset.
- States:
  - IDLE: no transfer.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- IDLE -> SETUP when any req_valid is high.
- SETUP -> ACCESS unconditionally after 1 cycle.
- ACCESS with pready=0: hold; all APB outputs stable.
- ACCESS with pready=1:
  - Completes the transfer.
  - Goes to SETUP if any req_valid is high (back-to-back transfer, no IDLE cycle), otherwise to IDLE.
- Acceptance: req_ready[g]=1 for exactly the grant winner g, only in IDLE or in ACCESS with pready=1, and only when req_valid[g]=1. A request is consumed on that cycle.
- Registered capture on acceptance: paddr, pwdata and pwrite are loaded from requester g at the clock edge. The captured values hold until the next acceptance.
- Requesters must hold valid, write, addr and wdata stable until req_ready is seen. Deasserting req_valid before grant is legal and withdraws the request.
- Round-robin: search starts at index (last_grant+1) mod NREQ, ascending with wrap. The pointer updates only on acceptance.
- Simultaneous requests: with all NREQ=4 valid continuously, the grant order is 0,1,2,3,0,...
- Response: on ACCESS completion, the cycle after the pready=1 edge:
  - rsp_valid[owner]=1 for exactly 1 cycle.
  - rsp_rdata=prdata for reads, 0 for writes.
  - rsp_err=pslverr.
- Back-to-back completion: a rsp_valid for transfer N and the SETUP of transfer N+1 share the same cycle.
- Throughput: 3 cycles per transfer with pready=1 (accept/IDLE, SETUP, ACCESS); 2 cycles per transfer when back-to-back.
- Reset mid-transfer: returns immediately to IDLE. No response is issued and the in-flight transfer is dropped.
- pwrite=0 and pwdata are don't-care for reads but still hold the captured value.

Optional Feature:
APB_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYC-1 with pready still 0, the transfer is forced complete: rsp_valid pulses, rsp_err=1, rsp_rdata=0, psel/penable drop.
  - The next state follows the normal ACCESS-completion rule.
- Not defined: no counter; ACCESS waits on pready indefinitely.

Decomposition:
- Package apb_arb_pkg:
  - State encoding: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
  - Localparam for pointer width, $clog2(NREQ).
  - Default TIMEOUT_CYC constant.
- Sub-module apb_rr_arbiter:
  - Inputs: req vector, enable.
  - Outputs: one-hot grant, grant index.
  - Owns the rr pointer register.
- The top level holds the FSM, capture registers, owner index and the optional timeout counter.

Test Plan:
- Single read: req_valid=4'b0010, addr 0x40, prdata 0xDEADBEEF, pready=1 -> SETUP then ACCESS, paddr=0x40, pwrite=0, rsp_valid=4'b0010, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Wait states: write from requester 3, addr 0x100, wdata 0x55, pready low for 3 ACCESS cycles -> paddr/pwdata/penable stable throughout, rsp_valid[3] one cycle after pready rises.
- Contention: all four valid, continuous -> grant order 0,1,2,3,0; back-to-back spacing 2 cycles; no IDLE cycles between transfers.
- Slave error: read with pslverr=1 on completion -> rsp_err=1 with rsp_valid; next transfer has rsp_err=0.
- Async reset: assert hresetn=0 during ACCESS -> all outputs 0 immediately; no rsp_valid; after release, requester 0 wins a 4'b1111 contention.
- APB_TIMEOUT_EN with TIMEOUT_CYC=16: pready held 0 -> after 16 ACCESS cycles rsp_valid pulses, rsp_err=1, rsp_rdata=0, psel=0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB master arbiter.
//
// Holds the FSM state encoding, the default parameter values and a helper
// that sizes the round-robin pointer / owner index. Imported by the
// interface, the round-robin arbiter and the top level.
package apb_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETUP  = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;

  localparam int DEFAULT_NREQ        = 4;
  localparam int DEFAULT_ADDR_W      = 32;
  localparam int DEFAULT_DATA_W      = 32;
  localparam int DEFAULT_TIMEOUT_CYC = 16;

  // Pointer width for an NREQ-entry requester index, $clog2(NREQ).
  function automatic int ptrWidth(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Bundle of requester-side and APB-side signals of the arbiter.
//
// Requester side: req_valid/req_write/req_addr/req_wdata in, req_ready out,
//   rsp_valid/rsp_rdata/rsp_err out. req_addr and req_wdata are flattened,
//   requester i sits at [i*W +: W].
// APB side: psel/penable/pwrite/paddr/pwdata out, prdata/pready/pslverr in.
// Modport master is used by the arbiter; slave is the mirror for the
// environment (requesters + APB slave).
interface apb_master_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int NREQ   = DEFAULT_NREQ,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;

  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [ADDR_W-1:0]      paddr;
  logic [DATA_W-1:0]      pwdata;
  logic [DATA_W-1:0]      prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter with its own rotating priority pointer.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : request vector, one bit per requester
//   en_i          : a grant may be issued this cycle
//   grant_o       : one-hot grant (zero when disabled or nothing requested)
//   grantIdx_o    : index of the winner of the current search
// The search starts at the pointer and wraps upward; the pointer moves to
// winner+1 only when a grant is actually issued. Reset pointer is 0, so
// requester 0 has top priority after reset.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NREQ-1:0]            req_i,
  input  logic                       en_i,
  output logic [NREQ-1:0]            grant_o,
  output logic [ptrWidth(NREQ)-1:0]  grantIdx_o
);

  localparam int PTR_W = ptrWidth(NREQ);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] winIdx;
  logic             found;

  // Wrap-around search from the pointer; first requester found wins.
  always_comb begin
    found   = 1'b0;
    winIdx  = '0;
    cand    = '0;
    grant_o = '0;
    ptr_d   = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NREQ);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winIdx = cand;
      end
    end
    if (en_i && found) begin
      grant_o[winIdx] = 1'b1;
      ptr_d = (winIdx == PTR_W'(NREQ - 1)) ? '0 : winIdx + PTR_W'(1);
    end
  end

  assign grantIdx_o = winIdx;

  // Priority pointer, advanced only when a grant is consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NREQ requesters.
//
// Ports:
//   hclk    : clock
//   hresetn : asynchronous active-low reset
//   bus     : apb_master_arbiter_if.master (requester handshake, response
//             pulse, APB master signals)
// Round-robin arbitration picks a requester in IDLE or on the completing
// ACCESS cycle; its address/data/direction are registered and driven
// through SETUP and ACCESS. One cycle after completion the owner gets a
// one-cycle rsp_valid with read data (0 for writes) and the error flag.
//
// Optional build macro APB_TIMEOUT_EN: forces completion with rsp_err=1
// after TIMEOUT_CYC ACCESS cycles without pready. Without it ACCESS waits
// on pready indefinitely.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ        = DEFAULT_NREQ,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input logic                  hclk,
  input logic                  hresetn,
  apb_master_arbiter_if.master bus
);

  localparam int PTR_W = ptrWidth(NREQ);

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  owner_q, grantIdx;
  logic [NREQ-1:0]   grant, ownerOneHot, rspValid_q;
  logic [ADDR_W-1:0] paddr_q, selAddr;
  logic [DATA_W-1:0] pwdata_q, selWdata, rspRdata_q;
  logic              pwrite_q, selWrite, rspErr_q;
  logic              inAccess, tmoHit, complete, arbEn, accept;

  assign inAccess = (state_q == ST_ACCESS);
  assign complete = inAccess & (bus.pready | tmoHit);
  // A new transfer may start from IDLE or overlap the completing ACCESS.
  assign arbEn    = (state_q == ST_IDLE) | complete;
  assign accept   = |grant;

  apb_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk_i      (hclk),
    .rst_ni     (hresetn),
    .req_i      (bus.req_valid),
    .en_i       (arbEn),
    .grant_o    (grant),
    .grantIdx_o (grantIdx)
  );

  assign bus.req_ready = grant;

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] waitCnt_q, waitCnt_d;

  // Wait-state counter: cleared in SETUP so it starts at 0 on ACCESS entry.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (state_q == ST_SETUP) begin
      waitCnt_d = '0;
    end else if (inAccess && !bus.pready && !tmoHit) begin
      waitCnt_d = waitCnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      waitCnt_q <= '0;
    end else begin
      waitCnt_q <= waitCnt_d;
    end
  end

  assign tmoHit = inAccess & ~bus.pready & (waitCnt_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  logic unusedTimeoutCyc;
  assign unusedTimeoutCyc = ^TIMEOUT_CYC;
  assign tmoHit = 1'b0;
`endif

  // Pick the winner's request fields and decode the owner into a one-hot.
  always_comb begin
    selAddr     = '0;
    selWdata    = '0;
    selWrite    = 1'b0;
    ownerOneHot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grantIdx == PTR_W'(i)) begin
        selAddr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        selWdata = bus.req_wdata[i*DATA_W +: DATA_W];
        selWrite = bus.req_write[i];
      end
      ownerOneHot[i] = (owner_q == PTR_W'(i));
    end
  end

  // IDLE -> SETUP -> ACCESS; completion chains straight into SETUP when
  // another request was accepted on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (complete) state_d = accept ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM, captured request, owner and the one-cycle response registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      rspValid_q <= '0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q  <= grantIdx;
        paddr_q  <= selAddr;
        pwdata_q <= selWdata;
        pwrite_q <= selWrite;
      end
      if (complete) begin
        rspValid_q <= ownerOneHot;
        rspRdata_q <= (pwrite_q | tmoHit) ? '0 : bus.prdata;
        rspErr_q   <= bus.pslverr | tmoHit;
      end else begin
        rspValid_q <= '0;
        rspRdata_q <= '0;
        rspErr_q   <= 1'b0;
      end
    end
  end

  assign bus.psel      = (state_q != ST_IDLE);
  assign bus.penable   = inAccess;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_rdata = rspRdata_q;
  assign bus.rsp_err   = rspErr_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all cross-checked every cycle against a
// transaction-level model of the arbiter.
module tb_apb_master_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 16;

  logic hclk = 1'b0;
  logic hresetn;

  always #5 hclk = ~hclk;

  apb_master_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  int nAssert = 0;
  int nFail   = 0;

  // Model: is a transfer in flight, is it in its ACCESS phase, who owns it,
  // what was captured, and which response is due this cycle.
  bit          mBusy, mAccess;
  int          mLast, mOwner, mWait;
  logic        mWrite;
  logic [31:0] mAddr, mWdata;
  bit          mRspV, mRspErr;
  int          mRspOwner;
  logic [31:0] mRspData;
  logic [NREQ-1:0] expReady;
  bit   [NREQ-1:0] pending;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mBusy = 0; mAccess = 0; mLast = NREQ - 1; mOwner = 0; mWait = 0;
    mWrite = 0; mAddr = '0; mWdata = '0;
    mRspV = 0; mRspErr = 0; mRspOwner = 0; mRspData = '0;
    expReady = '0;
  endtask

  // Compare DUT against the model for this cycle, then advance the model
  // across the coming clock edge using the inputs currently applied.
  task automatic compareAndStep();
    bit tmo, done, canAcc;
    int win;
    logic [NREQ-1:0] rdy, rspExp;
    tmo = 0;
`ifdef APB_TIMEOUT_EN
    tmo = mBusy && mAccess && !bus.pready && (mWait == TMO - 1);
`endif
    done   = mBusy && mAccess && (bus.pready || tmo);
    canAcc = !mBusy || done;
    win = -1;
    for (int k = 1; k <= NREQ; k++)
      if (win < 0 && bus.req_valid[(mLast + k) % NREQ]) win = (mLast + k) % NREQ;
    rdy = '0;
    if (canAcc && win >= 0) rdy[win] = 1'b1;
    rspExp = '0;
    if (mRspV) rspExp[mRspOwner] = 1'b1;

    checkOutput("req_ready", bus.req_ready, rdy);
    checkOutput("psel", bus.psel, mBusy);
    checkOutput("penable", bus.penable, mBusy && mAccess);
    checkOutput("paddr", bus.paddr, mAddr);
    checkOutput("pwdata", bus.pwdata, mWdata);
    checkOutput("pwrite", bus.pwrite, mWrite);
    checkOutput("rsp_valid", bus.rsp_valid, rspExp);
    if (mRspV) begin
      checkOutput("rsp_rdata", bus.rsp_rdata, mRspData);
      checkOutput("rsp_err", bus.rsp_err, mRspErr);
    end
    expReady = rdy;

    mRspV = done;
    if (done) begin
      mRspOwner = mOwner;
      mRspData  = (tmo || mWrite) ? 32'h0 : bus.prdata;
      mRspErr   = tmo ? 1'b1 : bus.pslverr;
    end
    if (rdy != '0) begin
      mLast  = win;
      mOwner = win;
      mAddr  = bus.req_addr[win*AW +: AW];
      mWdata = bus.req_wdata[win*DW +: DW];
      mWrite = bus.req_write[win];
      mBusy = 1; mAccess = 0;
    end else if (done) begin
      mBusy = 0; mAccess = 0;
    end else if (mBusy && !mAccess) begin
      mAccess = 1; mWait = 0;
    end else if (mBusy) begin
      mWait++;
    end
  endtask

  always @(negedge hclk) begin
    if (!hresetn) modelReset();
    else compareAndStep();
  end

  task automatic nextDrive();
    @(posedge hclk);
    #1;
  endtask

  task automatic toCheck();
    @(negedge hclk);
  endtask

  task automatic setReq(input int r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid[r] = 1'b1;
    bus.req_write[r] = w;
    bus.req_addr[r*AW +: AW]  = a;
    bus.req_wdata[r*DW +: DW] = d;
  endtask

  // Random requesters and APB slave; requests are held until the model
  // says they were accepted, occasionally withdrawn before that.
  task automatic applyStimulus();
    for (int i = 0; i < NREQ; i++) begin
      if (expReady[i]) begin
        pending[i] = 1'b0;
        bus.req_valid[i] = 1'b0;
      end
      if (!pending[i] && $urandom_range(0, 3) == 0) begin
        pending[i] = 1'b1;
        setReq(i, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom);
      end else if (pending[i] && $urandom_range(0, 31) == 0) begin
        pending[i] = 1'b0;
        bus.req_valid[i] = 1'b0;
      end
    end
    bus.pready  = ($urandom_range(0, 9) < 6);
    bus.pslverr = ($urandom_range(0, 4) == 0);
    bus.prdata  = $urandom;
  endtask

  initial begin
    hresetn = 1'b1;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    pending = '0;
    #2 hresetn = 1'b0;
    toCheck(); toCheck();
    checkOutput("rst_psel", bus.psel, 0);
    checkOutput("rst_penable", bus.penable, 0);
    checkOutput("rst_pwrite", bus.pwrite, 0);
    checkOutput("rst_paddr", bus.paddr, 0);
    checkOutput("rst_pwdata", bus.pwdata, 0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_rsp_rdata", bus.rsp_rdata, 0);
    checkOutput("rst_rsp_err", bus.rsp_err, 0);
    nextDrive();
    hresetn = 1'b1;

    $display("[TB] single read from requester 1");
    nextDrive();
    setReq(1, 1'b0, 32'h40, 32'h0);
    bus.pready = 1'b1; bus.prdata = 32'hDEAD_BEEF;
    toCheck(); checkOutput("rd_ready", bus.req_ready, 4'b0010);
    nextDrive(); bus.req_valid = '0;
    toCheck(); checkOutput("rd_setup_sel", {bus.psel, bus.penable}, 2'b10);
    checkOutput("rd_paddr", bus.paddr, 32'h40);
    checkOutput("rd_pwrite", bus.pwrite, 0);
    nextDrive(); toCheck(); checkOutput("rd_access", {bus.psel, bus.penable}, 2'b11);
    nextDrive(); toCheck();
    checkOutput("rd_rsp_valid", bus.rsp_valid, 4'b0010);
    checkOutput("rd_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    checkOutput("rd_rsp_err", bus.rsp_err, 0);

    $display("[TB] write with wait states from requester 3");
    nextDrive();
    setReq(3, 1'b1, 32'h100, 32'h55);
    bus.pready = 1'b0;
    toCheck(); checkOutput("ws_ready", bus.req_ready, 4'b1000);
    nextDrive(); bus.req_valid = '0;
    toCheck(); checkOutput("ws_setup", {bus.psel, bus.penable}, 2'b10);
    for (int k = 0; k < 4; k++) begin
      nextDrive();
      if (k == 3) bus.pready = 1'b1;
      toCheck();
      checkOutput("ws_hold_en", {bus.psel, bus.penable}, 2'b11);
      checkOutput("ws_hold_addr", bus.paddr, 32'h100);
      checkOutput("ws_hold_data", bus.pwdata, 32'h55);
      checkOutput("ws_no_rsp", bus.rsp_valid, 0);
    end
    nextDrive(); toCheck();
    checkOutput("ws_rsp_valid", bus.rsp_valid, 4'b1000);
    checkOutput("ws_rsp_rdata", bus.rsp_rdata, 0);

    $display("[TB] four-way contention");
    nextDrive();
    for (int r = 0; r < NREQ; r++) setReq(r, 1'b0, 32'h1000 + 32'(r * 4), 32'h0);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) nextDrive();
      toCheck();
      checkOutput("rr_order", bus.req_ready, (c % 2 == 0) ? (64'd1 << ((c / 2) % 4)) : 64'd0);
      if (c > 0) checkOutput("rr_no_idle", bus.psel, 1);
    end
    nextDrive(); bus.req_valid = '0;
    repeat (3) nextDrive();

    $display("[TB] slave error then clean read");
    setReq(2, 1'b0, 32'h2C, 32'h0);
    bus.pslverr = 1'b1; bus.prdata = 32'h1234_5678;
    toCheck(); checkOutput("err_ready", bus.req_ready, 4'b0100);
    nextDrive(); bus.req_valid = '0;
    nextDrive(); nextDrive(); bus.pslverr = 1'b0;
    toCheck();
    checkOutput("err_rsp_valid", bus.rsp_valid, 4'b0100);
    checkOutput("err_rsp_err", bus.rsp_err, 1);
    setReq(0, 1'b0, 32'h30, 32'h0);
    nextDrive(); bus.req_valid = '0;
    repeat (2) nextDrive();
    toCheck();
    checkOutput("err_next_valid", bus.rsp_valid, 4'b0001);
    checkOutput("err_next_err", bus.rsp_err, 0);

    $display("[TB] asynchronous reset during ACCESS");
    nextDrive();
    setReq(1, 1'b1, 32'h80, 32'hAA);
    bus.pready = 1'b0;
    nextDrive(); bus.req_valid = '0;
    nextDrive(); toCheck();
    checkOutput("ar_in_access", {bus.psel, bus.penable}, 2'b11);
    #2 hresetn = 1'b0;
    #1;
    checkOutput("ar_psel", bus.psel, 0);
    checkOutput("ar_penable", bus.penable, 0);
    checkOutput("ar_paddr", bus.paddr, 0);
    checkOutput("ar_pwdata", bus.pwdata, 0);
    checkOutput("ar_pwrite", bus.pwrite, 0);
    nextDrive(); nextDrive();
    hresetn = 1'b1; bus.pready = 1'b1;
    toCheck(); checkOutput("ar_no_rsp", bus.rsp_valid, 0);
    nextDrive();
    for (int r = 0; r < NREQ; r++) setReq(r, 1'b0, 32'h400 + 32'(r * 4), 32'h0);
    toCheck(); checkOutput("ar_req0_wins", bus.req_ready, 4'b0001);
    nextDrive(); bus.req_valid = '0;
    repeat (4) nextDrive();

    $display("[TB] randomized traffic");
    pending = '0;
    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      nextDrive();
    end
    bus.req_valid = '0; pending = '0;
    bus.pready = 1'b1; bus.pslverr = 1'b0;
    repeat (6) nextDrive();

`ifdef APB_TIMEOUT_EN
    $display("[TB] wait-state timeout");
    setReq(0, 1'b1, 32'h200, 32'h77);
    bus.pready = 1'b0;
    toCheck(); checkOutput("to_ready", bus.req_ready, 4'b0001);
    nextDrive(); bus.req_valid = '0;
    for (int k = 0; k < TMO; k++) begin
      nextDrive(); toCheck();
      checkOutput("to_waiting", {bus.penable, bus.rsp_valid}, 5'b10000);
    end
    nextDrive(); toCheck();
    checkOutput("to_rsp_valid", bus.rsp_valid, 4'b0001);
    checkOutput("to_rsp_err", bus.rsp_err, 1);
    checkOutput("to_rsp_rdata", bus.rsp_rdata, 0);
    checkOutput("to_psel", bus.psel, 0);
    nextDrive(); bus.pready = 1'b1;
    repeat (3) nextDrive();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
